// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one shift-add or restoring shift-subtract step per cycle,
// fixed DATA_WIDTH-cycle latency, result held on hi/lo until the next result or reset.
module mul_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo,
    output logic [1:0]            state_dbg
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready/out_valid depend only on state, never combinationally on the other side.
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [W-1:0]    opnd_q, opnd_d;
    logic            is_div_q, is_div_d;
    logic            neg_q, neg_d;
    logic            rem_neg_q, rem_neg_d;
    logic            dz_q, dz_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;

    logic [W-1:0]    abs_a, abs_b;
    logic [W:0]      mul_sum;
    logic [W:0]      shifted_rem;
    logic            ge;
    logic [W-1:0]    rem_sub;
    logic [2*W-1:0]  acc_step;
    logic [2*W-1:0]  prod;
    logic [W-1:0]    res_hi, res_lo;

    assign abs_a = (op[0] && src_a[W-1]) ? -src_a : src_a;
    assign abs_b = (op[0] && src_b[W-1]) ? -src_b : src_b;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    // Divide: acc = {partial remainder, dividend/quotient bits}, shifted left each step.
    always_comb begin
        mul_sum     = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? opnd_q : {W{1'b0}})};
        shifted_rem = {acc_q[2*W-1:W], acc_q[W-1]};
        ge          = shifted_rem >= {1'b0, opnd_q};
        rem_sub     = shifted_rem[W-1:0] - opnd_q;
        if (is_div_q) begin
            acc_step = {(ge ? rem_sub : shifted_rem[W-1:0]), acc_q[W-2:0], ge};
        end else begin
            acc_step = {mul_sum, acc_q[W-1:1]};
        end
        prod = neg_q ? -acc_step : acc_step;
        if (is_div_q) begin
            // Divide by zero leaves quotient all ones and remainder = |a|; the dividend
            // sign fix then restores src_a exactly, so only the quotient fix is suppressed.
            res_hi = rem_neg_q ? -acc_step[2*W-1:W] : acc_step[2*W-1:W];
            res_lo = (neg_q && !dz_q) ? -acc_step[W-1:0] : acc_step[W-1:0];
        end else begin
            res_hi = prod[2*W-1:W];
            res_lo = prod[W-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d   = CALC;
                    cnt_d     = '0;
                    is_div_d  = op[1];
                    neg_d     = op[0] & (src_a[W-1] ^ src_b[W-1]);
                    rem_neg_d = op[0] & src_a[W-1];
                    dz_d      = (src_b == '0);
                    opnd_d    = op[1] ? abs_b : abs_a;
                    acc_d     = {{W{1'b0}}, (op[1] ? abs_a : abs_b)};
                end
            end
            CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized and directed bench for mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [1:0]   state_dbg;

    int checks = 0;
    int errors = 0;
    logic [2*W-1:0] exp_q[$];

    mul_div_unit #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .src_a(src_a), .src_b(src_b), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .hi(hi), .lo(lo), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // MIPS semantics from plain integer arithmetic; SV signed division truncates toward zero
    // and the remainder follows the dividend, which is what DIV specifies.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: return {32'b0, a} * {32'b0, b};
            2'b01: return 64'(sa * sb);
            2'b10: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {32'(sa % sb), 32'(sa / sb)};
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input bit poke, input string tag);
        logic [63:0] exp;
        exp_q.push_back(ref_model(o, a, b));
        check_eq({tag, ":ready"}, 128'(in_ready), 128'(1));
        in_valid = 1'b1; op = o; src_a = a; src_b = b;
        tick();
        in_valid = 1'b0;
        op = 2'($urandom_range(0, 3)); src_a = $urandom; src_b = $urandom;
        for (int i = 1; i <= W; i++) begin
            tick();
            if (i == W - 1) check_eq({tag, ":early"}, 128'({in_ready, out_valid, busy}), 128'(3'b001));
        end
        check_eq({tag, ":done"}, 128'({in_ready, out_valid, busy}), 128'(3'b011));
        exp = exp_q.pop_front();
        check_eq({tag, ":hilo"}, 128'({hi, lo}), 128'(exp));
        out_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            if (poke && k == 3) begin
                in_valid = 1'b1; op = 2'b00; src_a = 32'd7; src_b = 32'd9;
            end
            tick();
            in_valid = 1'b0;
            check_eq({tag, ":hold"}, 128'({in_ready, out_valid, busy, hi, lo}), 128'({3'b011, exp}));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq({tag, ":taken"}, 128'({in_ready, out_valid, busy, hi, lo}), 128'({3'b100, exp}));
        if (poke) begin
            tick();
            check_eq({tag, ":noqueue"}, 128'({in_ready, busy, state_dbg}), 128'(4'b1000));
        end
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        tick();
        tick();
        rst = 1'b0;
        check_eq("reset", 128'({in_ready, out_valid, busy, hi, lo}), 128'({3'b100, 64'd0}));

        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, "multu_max");
        run_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 0, 1'b0, "mult_neg");
        run_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 0, 1'b0, "div_neg");
        run_op(2'b10, 32'd100, 32'd7, 0, 1'b0, "divu_100_7");
        run_op(2'b10, 32'd5, 32'd0, 0, 1'b0, "divu_by0");
        run_op(2'b11, 32'hFFFF_FFFB, 32'd0, 0, 1'b0, "div_by0");
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, "div_ovf");
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 0, 1'b0, "mult_min");
        run_op(2'b11, 32'd7, 32'hFFFF_FFFE, 0, 1'b0, "div_pos_neg");
        run_op(2'b00, 32'd3, 32'd5, 10, 1'b1, "hold10");

        for (int n = 0; n < 24; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 300));
            run_op(ro, ra, rb, int'($urandom_range(0, 3)), 1'b0, "rand");
        end

        // Reset sampled on the 10th CALC edge discards the in-flight product.
        in_valid = 1'b1; op = 2'b00; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= 9; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst", 128'({in_ready, out_valid, busy, hi, lo}), 128'({3'b100, 64'd0}));
        for (int i = 0; i < W + 4; i++) tick();
        check_eq("midrst_quiet", 128'({in_ready, out_valid, busy, hi, lo}), 128'({3'b100, 64'd0}));
        run_op(2'b00, 32'd3, 32'd4, 0, 1'b0, "after_rst");

        check_eq("queue_empty", 128'(exp_q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
